// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD pixel-scan path.
package lcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_FINISH = 2'd2
   } scan_state_t;

   localparam int unsigned DEF_H_PIXELS = 320;
   localparam int unsigned DEF_V_PIXELS = 240;
   localparam int unsigned LCD_PIX_W    = 16;
   localparam logic [15:0] RGB565_BLACK = 16'h0000;

   // Counter width helper that never collapses to zero bits for tiny geometries.
   function automatic int unsigned cntWidth(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lcd_scan_counter.sv
// x/y/linear-index position counters with selectable scan order and end-of-frame wrap.
module lcd_scan_counter
   import lcd_pkg::*;
#(
   parameter int unsigned H_PIXELS = DEF_H_PIXELS,
   parameter int unsigned V_PIXELS = DEF_V_PIXELS,
   parameter int unsigned XW       = cntWidth(H_PIXELS),
   parameter int unsigned YW       = cntWidth(V_PIXELS),
   parameter int unsigned IW       = cntWidth(H_PIXELS * V_PIXELS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          adv_i,
   input  logic          col_major_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic [IW-1:0] idx_o,
   output logic          wrap_o
);

   localparam logic [XW-1:0] X_LAST   = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_PIXELS - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(H_PIXELS * V_PIXELS - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [IW-1:0] idx_q, idx_d;

   assign wrap_o = adv_i && (idx_q == IDX_LAST);

   // The fast axis wraps into the slow axis; the final pixel zeroes everything at once.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      idx_d = idx_q;
      if (clr_i || wrap_o) begin
         x_d   = '0;
         y_d   = '0;
         idx_d = '0;
      end else if (adv_i) begin
         idx_d = idx_q + IW'(1);
         if (col_major_i) begin
            if (y_q == Y_LAST) begin
               y_d = '0;
               x_d = x_q + XW'(1);
            end else begin
               y_d = y_q + YW'(1);
            end
         end else begin
            if (x_q == X_LAST) begin
               x_d = '0;
               y_d = y_q + YW'(1);
            end else begin
               x_d = x_q + XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q   <= '0;
         y_q   <= '0;
         idx_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         idx_q <= idx_d;
      end
   end

   assign x_o   = x_q;
   assign y_o   = y_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/lcd_frame_scanner.sv
// Pixel-scan sequencer and source compositor for the SPI LCD path.
// Optional feature macro: SCANNER_UNDERRUN_CNT_EN enables the saturating underrun counter.
module lcd_frame_scanner
   import lcd_pkg::*;
#(
   parameter int unsigned H_PIXELS = DEF_H_PIXELS,
   parameter int unsigned V_PIXELS = DEF_V_PIXELS,
   parameter int unsigned NUM_SRC  = 4,
   parameter int unsigned PIX_W    = LCD_PIX_W
) (
   input  logic                                        clk_100MHz,
   input  logic                                        rst_n,
   input  logic                                        enable,
   input  logic                                        frame_rst,
   input  logic                                        col_major,
   input  logic [cntWidth(NUM_SRC)-1:0]                src_sel,
   input  logic [NUM_SRC*PIX_W-1:0]                    src_pixel,
   input  logic [NUM_SRC-1:0]                          src_valid,
   input  logic                                        pix_req,
   output logic [cntWidth(H_PIXELS)-1:0]               x,
   output logic [cntWidth(V_PIXELS)-1:0]               y,
   output logic [cntWidth(H_PIXELS*V_PIXELS)-1:0]      buf_index,
   output logic [PIX_W-1:0]                            pixel_out,
   output logic                                        pixel_valid,
   output logic [cntWidth(NUM_SRC)-1:0]                active_src,
   output logic                                        frame_start,
   output logic                                        frame_done,
   output logic [15:0]                                 underrun_cnt
);

   localparam int unsigned SW = cntWidth(NUM_SRC);

   scan_state_t   state_q, state_d;
   logic [SW-1:0] active_src_q, active_src_d;
   logic          col_major_q, col_major_d;
   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic          latch_sel;
   logic          scanning;
   logic          accept;
   logic          cnt_clr;
   logic          wrap;
   logic [PIX_W-1:0] sel_pixel;
   logic             sel_valid;

   // An out-of-range latched select (non power-of-two NUM_SRC) yields black and no valid.
   always_comb begin
      sel_pixel = PIX_W'(RGB565_BLACK);
      sel_valid = 1'b0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         if (active_src_q == SW'(k)) begin
            sel_pixel = src_pixel[k*PIX_W +: PIX_W];
            sel_valid = src_valid[k];
         end
      end
   end

   assign pixel_out   = sel_pixel;
   assign pixel_valid = (state_q != S_IDLE) && sel_valid;
   assign accept      = pix_req && pixel_valid && !frame_rst;
   assign cnt_clr     = (state_q == S_IDLE) || frame_rst;
   assign scanning    = (state_q == S_SCAN) || enable;

   lcd_scan_counter #(
      .H_PIXELS (H_PIXELS),
      .V_PIXELS (V_PIXELS)
   ) u_counter (
      .clk_i       (clk_100MHz),
      .rst_ni      (rst_n),
      .clr_i       (cnt_clr),
      .adv_i       (accept),
      .col_major_i (col_major_q),
      .x_o         (x),
      .y_o         (y),
      .idx_o       (buf_index),
      .wrap_o      (wrap)
   );

   // A wrap while still scanning starts the next frame in the same cycle, so no slot is lost.
   always_comb begin
      state_d       = state_q;
      latch_sel     = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d       = S_SCAN;
               latch_sel     = 1'b1;
               frame_start_d = 1'b1;
            end
         end
         S_SCAN, S_FINISH: begin
            state_d = enable ? S_SCAN : S_FINISH;
            if (frame_rst) begin
               latch_sel     = 1'b1;
               frame_start_d = 1'b1;
            end else if (wrap) begin
               frame_done_d = 1'b1;
               if (scanning) begin
                  latch_sel     = 1'b1;
                  frame_start_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign active_src_d = latch_sel ? src_sel   : active_src_q;
   assign col_major_d  = latch_sel ? col_major : col_major_q;

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         active_src_q  <= '0;
         col_major_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         active_src_q  <= active_src_d;
         col_major_q   <= col_major_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign active_src  = active_src_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;

`ifdef SCANNER_UNDERRUN_CNT_EN
   logic [15:0] underrun_q;
   logic        underrun;

   assign underrun = pix_req && !frame_rst && (state_q != S_IDLE) && !pixel_valid;

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         underrun_q <= '0;
      end else if (underrun && (underrun_q != 16'hFFFF)) begin
         underrun_q <= underrun_q + 16'd1;
      end
   end

   assign underrun_cnt = underrun_q;
`else
   assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Scoreboard bench for lcd_frame_scanner on a 4x3 panel with four sources.
module tb_lcd_frame_scanner;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int NPIX = H * V;

   localparam int MIDLE   = 0;
   localparam int MSCAN   = 1;
   localparam int MFINISH = 2;

   logic        clk;
   logic        rstN;
   logic        enable;
   logic        frameRst;
   logic        colMajor;
   logic [1:0]  srcSel;
   logic [63:0] srcPixel;
   logic [3:0]  srcValid;
   logic        pixReq;
   logic [1:0]  xOut;
   logic [1:0]  yOut;
   logic [3:0]  bufIndex;
   logic [15:0] pixelOut;
   logic        pixelValid;
   logic [1:0]  activeSrc;
   logic        frameStart;
   logic        frameDone;
   logic [15:0] underrunCnt;

   typedef struct {
      int x;
      int y;
      int idx;
      int fs;
      int fd;
      int act;
      int und;
      int pv;
      int pout;
   } exp_t;

   exp_t expQ[$];

   int compared   = 0;
   int mismatched = 0;

   // Reference model: linear position plus frame bookkeeping; x/y derived arithmetically.
   int mMode  = MIDLE;
   int mPos   = 0;
   int mAct   = 0;
   int mOrd   = 0;
   int mUnder = 0;
   int mFs    = 0;
   int mFd    = 0;

   lcd_frame_scanner #(
      .H_PIXELS (H),
      .V_PIXELS (V),
      .NUM_SRC  (4),
      .PIX_W    (16)
   ) dut (
      .clk_100MHz   (clk),
      .rst_n        (rstN),
      .enable       (enable),
      .frame_rst    (frameRst),
      .col_major    (colMajor),
      .src_sel      (srcSel),
      .src_pixel    (srcPixel),
      .src_valid    (srcValid),
      .pix_req      (pixReq),
      .x            (xOut),
      .y            (yOut),
      .buf_index    (bufIndex),
      .pixel_out    (pixelOut),
      .pixel_valid  (pixelValid),
      .active_src   (activeSrc),
      .frame_start  (frameStart),
      .frame_done   (frameDone),
      .underrun_cnt (underrunCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelStep(input bit en, input bit frst, input bit cm, input int sel,
                            input logic [3:0] vm, input bit req);
      bit valid;
      bit scanning;
      valid = (mMode != MIDLE) && vm[mAct];
      mFs = 0;
      mFd = 0;
      if (mMode == MIDLE) begin
         if (en) begin
            mMode = MSCAN;
            mAct  = sel;
            mOrd  = cm;
            mFs   = 1;
         end
      end else begin
         scanning = (mMode == MSCAN) || en;
         mMode = en ? MSCAN : MFINISH;
         if (frst) begin
            mPos = 0;
            mAct = sel;
            mOrd = cm;
            mFs  = 1;
         end else if (req && valid) begin
            if (mPos == NPIX - 1) begin
               mPos = 0;
               mFd  = 1;
               if (scanning) begin
                  mAct = sel;
                  mOrd = cm;
                  mFs  = 1;
               end else begin
                  mMode = MIDLE;
               end
            end else begin
               mPos++;
            end
         end else if (req) begin
            if (mUnder < 65535) mUnder++;
         end
      end
   endtask

   // Drives one cycle of inputs and queues the response expected after the next rising edge.
   task automatic applyStimulus(input bit en, input bit frst, input bit cm, input int sel,
                                input logic [3:0] vm, input bit req);
      exp_t e;
      logic [63:0] pix;
      @(negedge clk);
      pix      = {$urandom(), $urandom()};
      enable   = en;
      frameRst = frst;
      colMajor = cm;
      srcSel   = 2'(sel);
      srcValid = vm;
      srcPixel = pix;
      pixReq   = req;
      modelStep(en, frst, cm, sel, vm, req);
      e.x    = mOrd ? (mPos / V) : (mPos % H);
      e.y    = mOrd ? (mPos % V) : (mPos / H);
      e.idx  = mPos;
      e.fs   = mFs;
      e.fd   = mFd;
      e.act  = mAct;
`ifdef SCANNER_UNDERRUN_CNT_EN
      e.und  = mUnder;
`else
      e.und  = 0;
`endif
      e.pv   = ((mMode != MIDLE) && vm[mAct]) ? 1 : 0;
      e.pout = int'(pix[mAct*16 +: 16]);
      expQ.push_back(e);
   endtask

   // Monitor: pops one expectation per clock once the driver has queued one.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("x",            int'(xOut),        e.x);
            checkOutput("y",            int'(yOut),        e.y);
            checkOutput("buf_index",    int'(bufIndex),    e.idx);
            checkOutput("frame_start",  int'(frameStart),  e.fs);
            checkOutput("frame_done",   int'(frameDone),   e.fd);
            checkOutput("active_src",   int'(activeSrc),   e.act);
            checkOutput("underrun_cnt", int'(underrunCnt), e.und);
            checkOutput("pixel_valid",  int'(pixelValid),  e.pv);
            if (e.pv != 0) checkOutput("pixel_out", int'(pixelOut), e.pout);
         end
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, " x"},            int'(xOut),        0);
      checkOutput({tag, " y"},            int'(yOut),        0);
      checkOutput({tag, " buf_index"},    int'(bufIndex),    0);
      checkOutput({tag, " active_src"},   int'(activeSrc),   0);
      checkOutput({tag, " underrun_cnt"}, int'(underrunCnt), 0);
      checkOutput({tag, " frame_start"},  int'(frameStart),  0);
      checkOutput({tag, " frame_done"},   int'(frameDone),   0);
      checkOutput({tag, " pixel_valid"},  int'(pixelValid),  0);
   endtask

   initial begin
      bit en;
      bit cm;
      int sel;
      logic [3:0] vm;

      rstN     = 1'b0;
      enable   = 1'b0;
      frameRst = 1'b0;
      colMajor = 1'b0;
      srcSel   = '0;
      srcPixel = '0;
      srcValid = 4'hF;
      pixReq   = 1'b0;
      #22;
      checkResetState("reset");
      @(negedge clk);
      rstN = 1'b1;

      // Column-major frame; select and order change at pixel 5 take effect only at wrap.
      applyStimulus(1, 0, 1, 0, 4'hF, 0);
      for (int i = 0; i < NPIX; i++)
         applyStimulus(1, 0, (i >= 5) ? 1'b0 : 1'b1, (i >= 5) ? 2 : 0, 4'hF, 1);
      for (int i = 0; i < NPIX; i++)
         applyStimulus(1, 0, 0, 2, 4'hF, 1);

      // Active source stalls: three rejected requests.
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2, 4'b1011, 1);
      applyStimulus(1, 0, 0, 2, 4'hF, 0);

      // Advance to pixel 7, then restart the frame with a coincident request.
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 2, 4'hF, 1);
      applyStimulus(1, 1, 1, 1, 4'hF, 1);

      // Drop enable at pixel 4: frame completes, then requests are ignored.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 4'hF, 1);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, 4'hF, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 4'hF, 1);
      applyStimulus(0, 1, 0, 3, 4'hF, 1);

      // Randomised traffic.
      en  = 1'b1;
      cm  = 1'b0;
      sel = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) en = ~en;
         if ($urandom_range(0, 9) == 0) cm = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 9) == 0) sel = $urandom_range(0, 3);
         vm = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
         applyStimulus(en, $urandom_range(0, 63) == 0, cm, sel, vm,
                       $urandom_range(0, 3) != 0);
      end

      // Bring the scanner mid-frame, then abort with an asynchronous reset.
      applyStimulus(1, 1, 0, 3, 4'hF, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3, 4'hF, 1);
      applyStimulus(1, 0, 0, 3, 4'b0000, 1);
      @(negedge clk);
      checkOutput("pre-reset buf_index", int'(bufIndex), 5);
      rstN = 1'b0;
      #1;
      checkResetState("mid-frame reset");
      @(posedge clk);
      #1;
      checkOutput("held reset frame_done", int'(frameDone), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lcd_frame_scanner.md
# lcd_frame_scanner

Parametrised pixel-scan sequencer and source compositor for the SPI LCD path. Sits between the pixel-generating screens (cube state, colour choice, calibration, camera FIFO) and the LCD SPI controller. Replaces the edge-clocked buffer-index counter and the ad-hoc pixel muxing. Adds configurable frame geometry, row- or column-major scan order, N selectable sources, tear-free source switching at frame boundaries, and underrun stalling with an underrun count.

## Interface
- H_PIXELS, 320, panel width in pixels
- V_PIXELS, 240, panel height in pixels
- NUM_SRC, 4, number of pixel sources (min 2)
- PIX_W, 16, pixel width (RGB565)
- clk_100MHz  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  scan enable
- frame_rst  in  1  synchronous frame restart, single-cycle pulse
- col_major  in  1  1 = y fastest (column-major), 0 = x fastest
- src_sel  in  $clog2(NUM_SRC)  requested source
- src_pixel  in  NUM_SRC*PIX_W  packed source pixels; source k at [k*PIX_W +: PIX_W]
- src_valid  in  NUM_SRC  per-source pixel-available flag
- pix_req  in  1  one-cycle request from SPI controller: current pixel consumed
- x  out  $clog2(H_PIXELS)  current column
- y  out  $clog2(V_PIXELS)  current row
- buf_index  out  $clog2(H_PIXELS*V_PIXELS)  linear pixel index
- pixel_out  out  PIX_W  pixel of active source
- pixel_valid  out  1  active source valid and state is S_SCAN or S_FINISH
- active_src  out  $clog2(NUM_SRC)  source latched for current frame
- frame_start  out  1  one-cycle pulse at the start of each frame
- frame_done  out  1  one-cycle pulse when the last pixel is consumed
- underrun_cnt  out  16  saturating count of rejected requests

## Operation
- States: S_IDLE, S_SCAN, S_FINISH.
- S_IDLE: counters held at 0; pix_req ignored. enable=1 → S_SCAN. Entry latches src_sel and col_major and pulses frame_start.
- S_SCAN: an accepted request (pix_req & pixel_valid) advances position.
  - Column-major: y increments; at y=V_PIXELS-1, y wraps to 0 and x increments.
  - Row-major: the same with x and y swapped.
  - buf_index increments by 1 on every accepted request.
- enable=0 during S_SCAN → S_FINISH. The current frame completes and further requests are accepted. At wrap, the block enters S_IDLE with no frame_start pulse. enable=1 during S_FINISH → S_SCAN; the frame is not interrupted.
- Wrap: an accepted request at buf_index = H_PIXELS*V_PIXELS-1 sets x, y and buf_index to 0 and pulses frame_done. In S_SCAN the same cycle re-latches src_sel and col_major and pulses frame_start, so no pixel slot is lost.
- src_sel and col_major changes mid-frame have no effect until the next wrap or frame_rst.
- Underrun: pix_req while pixel_valid=0 in S_SCAN/S_FINISH leaves position unchanged and increments underrun_cnt, saturating at 16'hFFFF.
- frame_rst outside S_IDLE zeroes the counters, re-latches the selects and pulses frame_start. frame_rst takes priority over a coincident pix_req; that request is neither counted nor flagged as an underrun. In S_IDLE, frame_rst is ignored.
- pixel_out is a combinational mux of src_pixel by active_src. pixel_valid is combinational from src_valid[active_src] and state.

## Timing
- Reset values:
  - state S_IDLE
  - x, y, buf_index, active_src and underrun_cnt at 0
  - frame_start and frame_done at 0
  - pixel_valid at 0
- An accepted pix_req at edge N updates x, y and buf_index after edge N. Sources see the new coordinates in cycle N+1. pixel_out follows with zero added latency.
- frame_start and frame_done are registered, asserted for exactly one cycle after the triggering edge.
- Back-to-back pix_req on consecutive cycles is legal; sustained rate is one pixel per clock.
- Reset mid-frame aborts immediately to the reset values; no frame_done is emitted.

## Configuration
- SCANNER_UNDERRUN_CNT_EN defined: underrun counter and its saturation logic are present.
- SCANNER_UNDERRUN_CNT_EN undefined: underrun_cnt is tied to 0. Stalling on underrun still applies.

## Structure
- Shared package lcd_pkg:
  - scan_state_t enum (S_IDLE, S_SCAN, S_FINISH)
  - default H_PIXELS and V_PIXELS constants
  - PIX_W constant
  - RGB565 black constant
- Sub-module lcd_scan_counter: the x/y/index counters with order select and wrap flag.
- The FSM, select latching and mux stay in lcd_frame_scanner.

## Test plan
- H=4, V=3, col_major=1, all sources valid, 12 consecutive pix_req → sequence (0,0),(0,1),(0,2),(1,0)…(3,2); frame_done once after the 12th request; x=y=buf_index=0; second frame_start in the same cycle.
- col_major=0, same stimulus → (0,0),(1,0),(2,0),(3,0),(0,1)…; buf_index reaches 11 before wrap.
- src_sel changed 0→2 at pixel 5 → active_src stays 0 until wrap, then becomes 2 with the frame_start pulse.
- src_valid[active]=0 with 3 pix_req → position unchanged, underrun_cnt=3 (0 when SCANNER_UNDERRUN_CNT_EN undefined).
- enable dropped at pixel 4 → pixels 4–11 still accepted; frame_done pulses, state S_IDLE; later pix_req ignored.
- frame_rst coincident with pix_req at pixel 7 → counters 0, frame_start pulse, underrun_cnt unchanged; rst_n low mid-frame → all outputs at reset values.
